// File: rtl/ntt_bank_addr_gen.sv
// ntt_bank_addr_gen: sequences in-place radix-2 NTT stages, issuing conflict-free
// two-bank read pairs, twiddle indices and pipeline-aligned write-back pairs.
module ntt_bank_addr_gen #(
  parameter int LOGN = 8,
  parameter int BFU_LAT = 4,
  localparam int AW = LOGN - 1,
  localparam int D = BFU_LAT + 1,
  localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] stage,
  output logic          ren,
  output logic [AW-1:0] rd_addr0,
  output logic [AW-1:0] rd_addr1,
  output logic          rd_swap,
  output logic [LOGN-1:0] tw_idx,
  output logic          wen,
  output logic [AW-1:0] wr_addr0,
  output logic [AW-1:0] wr_addr1,
  output logic          wr_swap,
  output logic          bank_en
);
  localparam int W = 2 * AW + 2;
  localparam int CW = $clog2(D + 1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [AW-1:0] j_q, j_d;
  logic [CW-1:0] dc_q, dc_d;
  logic ren_q, ren_d, swap_q, swap_d;
  logic [AW-1:0] a0_q, a0_d, a1_q, a1_d;
  logic [LOGN-1:0] tw_q, tw_d;
  logic [D-1:0][W-1:0] pipe_q, pipe_d;
  logic [LOGN-1:0] jx, half, i0, i1;
  logic [SW:0] sh;
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    j_d = j_q;
    dc_d = dc_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        s_d = '0;
        j_d = '0;
      end
      READ: begin
        j_d = j_q + 1'b1;
        dc_d = '0;
        state_d = &j_q ? DRAIN : READ;
      end
      DRAIN: begin
        dc_d = dc_q + 1'b1;
        if (dc_q == CW'(D - 1)) begin
          dc_d = '0;
          state_d = (s_q == SW'(LOGN - 1)) ? DONE : READ;
          s_d = (s_q == SW'(LOGN - 1)) ? s_q : s_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        s_d = '0;
      end
    endcase
  end
  // i0 inserts a zero at bit (LOGN-1-s) of j; i1 sets that bit, so parities differ
  always_comb begin
    sh = (SW + 1)'(LOGN - 1) - (SW + 1)'(s_d);
    jx = LOGN'(j_d);
    half = LOGN'(1) << sh;
    i0 = ((jx & ~(half - 1'b1)) << 1) | (jx & (half - 1'b1));
    i1 = i0 | half;
    ren_d = state_d == READ;
    swap_d = ren_d & (^i0);
    a0_d = ren_d ? (swap_d ? i1[LOGN-1:1] : i0[LOGN-1:1]) : '0;
    a1_d = ren_d ? (swap_d ? i0[LOGN-1:1] : i1[LOGN-1:1]) : '0;
    tw_d = ren_d ? (LOGN'(1) << s_d) + (jx >> sh) : '0;
    pipe_d[0] = {ren_q, a0_q, a1_q, swap_q};
    for (int k = 1; k < D; k++) pipe_d[k] = pipe_q[k-1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q <= '0;
      j_q <= '0;
      dc_q <= '0;
      ren_q <= 1'b0;
      swap_q <= 1'b0;
      a0_q <= '0;
      a1_q <= '0;
      tw_q <= '0;
      pipe_q <= '0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      j_q <= j_d;
      dc_q <= dc_d;
      ren_q <= ren_d;
      swap_q <= swap_d;
      a0_q <= a0_d;
      a1_q <= a1_d;
      tw_q <= tw_d;
      pipe_q <= pipe_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign stage = s_q;
  assign ren = ren_q;
  assign rd_addr0 = a0_q;
  assign rd_addr1 = a1_q;
  assign rd_swap = swap_q;
  assign tw_idx = tw_q;
  assign wen = pipe_q[D-1][W-1];
  assign wr_addr0 = pipe_q[D-1][W-2 -: AW];
  assign wr_addr1 = pipe_q[D-1][AW:1];
  assign wr_swap = pipe_q[D-1][0];
  assign bank_en = ren_q | wen;
endmodule

// File: tb/tb_ntt_bank_addr_gen.sv
// tb_ntt_bank_addr_gen: random start/reset stimulus checked every cycle against
// an arithmetic model of the stage/butterfly schedule, plus literal anchors.
module tb_ntt_bank_addr_gen;
  localparam int LOGN = 3, BFU_LAT = 2, D = BFU_LAT + 1, N = 1 << LOGN, H = N / 2;
  localparam int P = H + D, T = LOGN * P + 1, AW = LOGN - 1, SW = 2;
  logic clk = 0, rst = 1, start = 0;
  logic busy, done, ren, rd_swap, wen, wr_swap, bank_en;
  logic [SW-1:0] stage;
  logic [AW-1:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
  logic [LOGN-1:0] tw_idx;
  int total = 0, bad = 0, cyc = 0, run_start = -1;

  ntt_bank_addr_gen #(.LOGN(LOGN), .BFU_LAT(BFU_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .stage(stage),
    .ren(ren), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_swap(rd_swap),
    .tw_idx(tw_idx), .wen(wen), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_swap(wr_swap), .bank_en(bank_en));

  always #5 clk = ~clk;

  function automatic bit active(int c);
    return run_start >= 0 && c - run_start >= 1 && c - run_start <= T;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  // read issued t cycles after start was accepted: stage s, butterfly j
  function automatic void model_rd(input int t, output int v, output int a0, output int a1,
                                   output int sw, output int tw, output int s);
    int k, j, half, i0, i1;
    v = 0; a0 = 0; a1 = 0; sw = 0; tw = 0; s = 0;
    if (t < 1) return;
    s = (t - 1) / P;
    k = (t - 1) % P;
    if (s >= LOGN || k >= H) return;
    j = k;
    v = 1;
    half = N >> (s + 1);
    i0 = (j / half) * 2 * half + j % half;
    i1 = i0 + half;
    sw = $countones(i0) % 2;
    a0 = (sw ? i1 : i0) / 2;
    a1 = (sw ? i0 : i1) / 2;
    tw = (1 << s) + (j >> (LOGN - 1 - s));
  endfunction

  always @(posedge clk) begin
    if (rst) run_start = -1;
    else if (start && !active(cyc)) run_start = cyc;
    cyc++;
  end

  always @(negedge clk) begin
    int t, v, a0, a1, sw, tw, s, wv, wa0, wa1, wsw, wtw, ws;
    t = (run_start >= 0 && !rst) ? cyc - run_start : -100;
    model_rd(t, v, a0, a1, sw, tw, s);
    model_rd(t - D, wv, wa0, wa1, wsw, wtw, ws);
    chk("busy", busy, int'(t >= 1 && t <= T));
    chk("done", done, int'(t == T));
    chk("ren", ren, v);
    chk("wen", wen, wv);
    chk("bank_en", bank_en, v | wv);
    if (v) begin
      chk("rd_addr0", rd_addr0, a0);
      chk("rd_addr1", rd_addr1, a1);
      chk("rd_swap", rd_swap, sw);
      chk("tw_idx", tw_idx, tw);
      chk("stage", stage, s);
    end
    if (wv) begin
      chk("wr_addr0", wr_addr0, wa0);
      chk("wr_addr1", wr_addr1, wa1);
      chk("wr_swap", wr_swap, wsw);
    end
    if (rst) begin
      chk("rst_rd_addr0", rd_addr0, 0);
      chk("rst_rd_addr1", rd_addr1, 0);
      chk("rst_tw_idx", tw_idx, 0);
      chk("rst_wr_addr0", wr_addr0, 0);
      chk("rst_wr_addr1", wr_addr1, 0);
      chk("rst_swaps", {rd_swap, wr_swap}, 0);
      chk("rst_stage", stage, 0);
    end
  end

  task automatic go(int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int b;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    go(cyc + 2);
    b = cyc;
    start = 1;
    go(b + 1);
    start = 0;
    @(negedge clk);
    chk("lit_j0_a0", rd_addr0, 0);
    chk("lit_j0_a1", rd_addr1, 2);
    chk("lit_j0_swap", rd_swap, 0);
    chk("lit_j0_tw", tw_idx, 1);
    go(b + 2);
    @(negedge clk);
    chk("lit_j1_a0", rd_addr0, 2);
    chk("lit_j1_a1", rd_addr1, 0);
    chk("lit_j1_swap", rd_swap, 1);
    chk("lit_j1_tw", tw_idx, 1);
    go(b + 4);
    @(negedge clk);
    chk("lit_wen4", wen, 1);
    chk("lit_wr4_a1", wr_addr1, 2);
    go(b + 5);
    start = 1;
    go(b + 6);
    start = 0;
    go(b + 7);
    @(negedge clk);
    chk("lit_wen7", wen, 1);
    chk("lit_ren7", ren, 0);
    for (int k = 15; k <= 18; k++) begin
      go(b + k);
      @(negedge clk);
      chk("lit_tw_s2", tw_idx, 4 + k - 15);
    end
    go(b + 21);
    @(negedge clk);
    chk("lit_done21", done, 0);
    go(b + 22);
    @(negedge clk);
    chk("lit_done22", done, 1);
    go(b + 23);
    @(negedge clk);
    chk("lit_busy23", busy, 0);
    start = 1;
    b = b + 23;
    go(b + 1);
    start = 0;
    @(negedge clk);
    chk("lit_rerun_ren", ren, 1);
    go(b + 9);
    rst = 1;
    @(negedge clk);
    chk("lit_rst_ren", ren, 0);
    chk("lit_rst_busy", busy, 0);
    go(b + 10);
    rst = 0;
    go(b + 40);
    start = 1;
    b = cyc;
    go(b + 1);
    start = 0;
    @(negedge clk);
    chk("lit_fresh_stage", stage, 0);
    chk("lit_fresh_a1", rd_addr1, 2);
    repeat (4000) begin
      start = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 299) == 0);
      @(posedge clk);
      #1;
    end
    rst = 0;
    start = 0;
    go(cyc + T + D + 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ntt_bank_addr_gen.md
Name: ntt_bank_addr_gen

Overview:
- Control and address generator that sits directly upstream of the two coefficient data banks (bank0, bank1) feeding the radix-2 butterfly datapath.
- For an in-place Cooley-Tukey NTT of N = 2^LOGN coefficients, it sequences all stages and butterflies.
- Each cycle it issues one conflict-free read pair (one index per bank), a twiddle index, and a matching write pair delayed to line up with the butterfly pipeline, so results are written back in place.

Parameters:
- LOGN, 8, log2 of transform size; N = 2^LOGN coefficients, each bank depth N/2.
- BFU_LAT, 4, butterfly pipeline latency in cycles from bank Q valid to butterfly result valid (min 1).
- Derived (local, not overridable): AW = LOGN-1 bank address width; D = BFU_LAT+1 read-to-write delay.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request to run a full NTT; ignored unless in IDLE.
- busy  out  1  high from the cycle after start is accepted until done inclusive.
- done  out  1  one-cycle pulse after the last write of the last stage.
- stage  out  LOGN-bit-safe width ceil(log2(LOGN))  current stage number s.
- ren  out  1  read enable to both banks.
- rd_addr0  out  AW  read address, bank0.
- rd_addr1  out  AW  read address, bank1.
- rd_swap  out  1  0: lower index i0 is in bank0; 1: i0 is in bank1.
- tw_idx  out  LOGN  twiddle ROM index for the butterfly being read.
- wen  out  1  write enable to both banks.
- wr_addr0  out  AW  write address, bank0.
- wr_addr1  out  AW  write address, bank1.
- wr_swap  out  1  rd_swap delayed by D cycles, for the output crossbar.
- bank_en  out  1  ren | wen.

Behaviour:
- Reset: asynchronous, active-high. All outputs 0, FSM to IDLE, counters 0, delay pipeline cleared.
- Index math: for stage s, half = N >> (s+1), butterfly j = 0..N/2-1.
  - i0 = (j / half)*2*half + (j mod half); i1 = i0 + half.
  - bank(i) = XOR of all bits of i; addr(i) = i >> 1.
  - i0 and i1 differ in exactly one bit, so they are always in opposite banks.
  - rd_swap = bank(i0); rd_addrX = addr of whichever of i0/i1 lies in bankX.
- tw_idx = 2^s + (j >> (LOGN-1-s)), bit-reversed-order twiddle table.
- FSM states:
  - IDLE: start=1 -> READ with s=0, j=0.
  - READ: ren=1 with addresses for (s,j) each cycle; j increments. At j = N/2-1 go to DRAIN, j -> 0.
  - DRAIN: ren=0 for exactly D cycles, so the last write of the stage completes before the next stage's first read (RAW hazard on in-place data). At end of DRAIN: if s < LOGN-1, then s++ and go to READ; else go to DONE.
  - DONE: done=1 for one cycle, busy=1, then IDLE.
- Address and control outputs are registered; read outputs change on the edge that enters or advances READ.
- Write path:
  - A D-deep shift register carries {valid, rd_addr0, rd_addr1, rd_swap}.
  - wen, wr_addr0, wr_addr1 and wr_swap equal the read values from exactly D cycles earlier.
  - wen=1 for exactly N/2 cycles per stage.
- start while busy is ignored and has no effect.
- rst mid-run aborts immediately: no further ren or wen, and no done pulse.
- Per-run cycle count, from the first ren cycle to the done cycle: LOGN*(N/2 + D).

Test Plan:
- LOGN=3, BFU_LAT=2 (D=3), start in cycle 0:
  - ren high cycles 1-4, 8-11, 15-18.
  - done pulses in cycle 22 only; busy high cycles 1-22.
- Same config, stage 0 reads:
  - j=0: rd_addr0=0, rd_addr1=2, rd_swap=0, tw_idx=1.
  - j=1 (i0=1, i1=5): rd_addr0=2, rd_addr1=0, rd_swap=1, tw_idx=1.
- Same config, write path:
  - wen high cycles 4-7, 11-14, 18-21.
  - wr_addr0, wr_addr1 and wr_swap in cycle t+3 equal the read values in cycle t.
- Same config, stage 2 (half=1):
  - tw_idx sequence 4,5,6,7.
  - In every read cycle, the bank(i0) != bank(i1) check holds.
- Assert rst in cycle 9, mid stage 1:
  - All outputs 0 in the same cycle.
  - No wen after release, no done.
  - A fresh start rereads stage 0 from j=0.
- start pulsed again in cycle 5 during a run:
  - Ignored; the done timing is unchanged.
  - A start in the cycle after done begins a new run.
